bp_nonsynth_resp_drain: RTL and testbench

Parametrised, multi-channel, nonsynthesizable response sink for FE/ME unit benches. It replaces the single output FIFO plus random-yumi-generator pair that sits between a cache data port and trace replay. Each channel buffers valid-only responses in its own FIFO and applies its own random dequeue delay. A round-robin arbiter merges the channels into one ready&valid stream for the checker. A sticky overflow flag catches producers that ignore backpressure.

---
 rtl/bp_nonsynth_drain_pkg.sv | 20 ++
 rtl/bp_nonsynth_drain_chan.sv | 70 +++++++
 rtl/bp_nonsynth_resp_drain.sv | 129 ++++++++++++
 tb/tb_bp_nonsynth_resp_drain.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_drain_pkg.sv
// Shared constants and width helpers for the nonsynthesizable response drain.
package bp_nonsynth_drain_pkg;

  localparam int unsigned lfsr_width_lp = 16;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [lfsr_width_lp-1:0] lfsr_taps_lp = 16'hB400;

  function automatic int unsigned delay_width(input int unsigned max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

  function automatic int unsigned chan_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/bp_nonsynth_drain_chan.sv
// One drain channel: small circular FIFO, occupancy counter and a reloadable
// dequeue-delay counter that gates eligibility.
module bp_nonsynth_drain_chan
  import bp_nonsynth_drain_pkg::*;
#(
  parameter int unsigned width_p     = 32,
  parameter int unsigned els_p       = 16,
  parameter int unsigned min_delay_p = 0,
  parameter int unsigned max_delay_p = 15,
  localparam int unsigned count_width_lp = count_width(els_p),
  localparam int unsigned delay_width_lp = delay_width(max_delay_p)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_v,
  input  logic [width_p-1:0]        push_data,
  output logic                      full,
  input  logic                      yumi,
  input  logic [delay_width_lp-1:0] reload,
  output logic [width_p-1:0]        head_data,
  output logic [count_width_lp-1:0] count,
  output logic                      eligible
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);

  logic [width_p-1:0]        mem_q [els_p];
  logic [ptr_width_lp-1:0]   wptr_q, rptr_q;
  logic [count_width_lp-1:0] count_q;
  logic [delay_width_lp-1:0] delay_q;
  logic                      push;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == count_width_lp'(els_p));
  assign push      = push_v & ~full;
  assign head_data = mem_q[rptr_q];
  assign count     = count_q;
  assign eligible  = (count_q != '0) && (delay_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      delay_q <= delay_width_lp'(min_delay_p);
    end else begin
      if (push) wptr_q <= next_ptr(wptr_q);
      if (yumi) rptr_q <= next_ptr(rptr_q);
      if (push && !yumi) begin
        count_q <= count_q + 1'b1;
      end else if (!push && yumi) begin
        count_q <= count_q - 1'b1;
      end
      // Counter runs down regardless of occupancy; only a dequeue reloads it.
      if (yumi) begin
        delay_q <= reload;
      end else if (delay_q != '0) begin
        delay_q <= delay_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/bp_nonsynth_resp_drain.sv
// Multi-channel random-delay response sink merged by a round-robin arbiter.
// Define BP_NONSYNTH_DRAIN_TRACE_EN to print transfers, overflow and per-channel totals.
module bp_nonsynth_resp_drain
  import bp_nonsynth_drain_pkg::*;
#(
  parameter int unsigned width_p     = 32,
  parameter int unsigned els_p       = 16,
  parameter int unsigned channels_p  = 1,
  parameter int unsigned min_delay_p = 0,
  parameter int unsigned max_delay_p = 15,
  parameter logic [15:0] seed_p      = 16'h0001,
  localparam int unsigned count_width_lp = count_width(els_p),
  localparam int unsigned chan_width_lp  = chan_width(channels_p),
  localparam int unsigned delay_width_lp = delay_width(max_delay_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [channels_p-1:0]                v_i,
  input  logic [channels_p*width_p-1:0]        data_i,
  output logic [channels_p-1:0]                ready_and_o,
  output logic                                 v_o,
  output logic [width_p-1:0]                   data_o,
  output logic [chan_width_lp-1:0]             chan_o,
  input  logic                                 ready_and_i,
  output logic [channels_p*count_width_lp-1:0] count_o,
  output logic                                 overflow_o
);

  if (min_delay_p > max_delay_p) begin : g_bad_delay
    $error("bp_nonsynth_resp_drain: min_delay_p (%0d) > max_delay_p (%0d)",
           min_delay_p, max_delay_p);
  end

  localparam logic [15:0] seed_lp = (seed_p == 16'h0000) ? 16'h0001 : seed_p;
  localparam int unsigned span_lp = max_delay_p - min_delay_p + 1;

  logic [lfsr_width_lp-1:0]  lfsr_q;
  logic [delay_width_lp-1:0] reload;
  logic [channels_p-1:0]     full, eligible, yumi;
  logic [width_p-1:0]        head_data [channels_p];
  logic [chan_width_lp-1:0]  rr_q, winner;
  logic                      any_v, overflow_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= seed_lp;
    else         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & lfsr_taps_lp)};
  end

  // With span_lp == 1 the modulo is zero, so the reload is the constant min_delay_p.
  assign reload = delay_width_lp'(min_delay_p + (32'(lfsr_q) % span_lp));

  for (genvar c = 0; c < channels_p; c++) begin : g_chan
    bp_nonsynth_drain_chan #(
      .width_p    (width_p),
      .els_p      (els_p),
      .min_delay_p(min_delay_p),
      .max_delay_p(max_delay_p)
    ) u_chan (
      .clk      (clk_i),
      .reset    (reset_i),
      .push_v   (v_i[c]),
      .push_data(data_i[c*width_p +: width_p]),
      .full     (full[c]),
      .yumi     (yumi[c]),
      .reload   (reload),
      .head_data(head_data[c]),
      .count    (count_o[c*count_width_lp +: count_width_lp]),
      .eligible (eligible[c])
    );
    assign yumi[c] = any_v & ready_and_i & (winner == chan_width_lp'(c));
  end

  assign ready_and_o = ~full;

  // Search starts just after the last winner and wraps.
  always_comb begin
    any_v  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= channels_p; i++) begin
      if (!any_v && eligible[(32'(rr_q) + i) % channels_p]) begin
        any_v  = 1'b1;
        winner = chan_width_lp'((32'(rr_q) + i) % channels_p);
      end
    end
  end

  assign v_o    = any_v;
  assign data_o = head_data[winner];
  assign chan_o = winner;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q       <= chan_width_lp'(channels_p - 1);
      overflow_q <= 1'b0;
    end else begin
      if (any_v && ready_and_i) rr_q <= winner;
      overflow_q <= overflow_q | (|(v_i & full));
    end
  end

  assign overflow_o = overflow_q;

`ifdef BP_NONSYNTH_DRAIN_TRACE_EN
  int unsigned xfer_cnt_q [channels_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < channels_p; c++) xfer_cnt_q[c] <= 0;
    end else begin
      if (any_v && ready_and_i) begin
        $display("[drain] t=%0t ch=%0d data=%h", $time, winner, data_o);
        xfer_cnt_q[winner] <= xfer_cnt_q[winner] + 1;
      end
      if (!overflow_q) begin
        for (int c = 0; c < channels_p; c++) begin
          if (v_i[c] && full[c]) $error("[drain] overflow on channel %0d", c);
        end
      end
    end
  end

  final begin
    for (int c = 0; c < channels_p; c++) begin
      $display("[drain] channel %0d transfers=%0d", c, xfer_cnt_q[c]);
    end
  end
`endif

endmodule

// File: tb/tb_bp_nonsynth_resp_drain.sv
// Bench for bp_nonsynth_resp_drain: four instances cover latency, overflow, reset,
// round-robin order, fixed delay and random delay with per-channel scoreboards.
module tb_bp_nonsynth_resp_drain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, val, lo, hi, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A: 1 channel, no delay
  logic        a_v_i, a_rdy_o, a_v_o, a_chan_o, a_rdy_i, a_ovf_o;
  logic [31:0] a_data_i, a_data_o;
  logic [4:0]  a_count_o;
  logic [31:0] qa [$];

  bp_nonsynth_resp_drain #(.width_p(32), .els_p(16), .channels_p(1),
                           .min_delay_p(0), .max_delay_p(0)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(a_v_i), .data_i(a_data_i), .ready_and_o(a_rdy_o),
    .v_o(a_v_o), .data_o(a_data_o), .chan_o(a_chan_o), .ready_and_i(a_rdy_i),
    .count_o(a_count_o), .overflow_o(a_ovf_o)
  );

  // B: 3 channels, no delay
  typedef struct packed {logic [31:0] d; logic [1:0] ch;} bexp_t;
  logic [2:0]  b_v_i, b_rdy_o;
  logic [95:0] b_data_i;
  logic        b_v_o, b_rdy_i, b_ovf_o;
  logic [31:0] b_data_o;
  logic [1:0]  b_chan_o;
  logic [14:0] b_count_o;
  bexp_t       qb [$];

  bp_nonsynth_resp_drain #(.width_p(32), .els_p(16), .channels_p(3),
                           .min_delay_p(0), .max_delay_p(0)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(b_v_i), .data_i(b_data_i), .ready_and_o(b_rdy_o),
    .v_o(b_v_o), .data_o(b_data_o), .chan_o(b_chan_o), .ready_and_i(b_rdy_i),
    .count_o(b_count_o), .overflow_o(b_ovf_o)
  );

  // C: 2 channels, random delay 2..5
  logic [1:0]  c_v_i, c_rdy_o, c_pend;
  logic [63:0] c_data_i;
  logic        c_v_o, c_rdy_i, c_ovf_o, c_chan_o;
  logic [31:0] c_data_o;
  logic [9:0]  c_count_o;
  logic [31:0] qc [2][$];

  bp_nonsynth_resp_drain #(.width_p(32), .els_p(16), .channels_p(2),
                           .min_delay_p(2), .max_delay_p(5), .seed_p(16'hACE1)) dut_c (
    .clk_i(clk), .reset_i(rst), .v_i(c_v_i), .data_i(c_data_i), .ready_and_o(c_rdy_o),
    .v_o(c_v_o), .data_o(c_data_o), .chan_o(c_chan_o), .ready_and_i(c_rdy_i),
    .count_o(c_count_o), .overflow_o(c_ovf_o)
  );

  // D: 1 channel, fixed delay 3
  logic        d_v_i, d_rdy_o, d_v_o, d_chan_o, d_rdy_i, d_ovf_o;
  logic [31:0] d_data_i, d_data_o;
  logic [4:0]  d_count_o;
  logic [31:0] qd [$];
  int          d_cyc [$];

  bp_nonsynth_resp_drain #(.width_p(32), .els_p(16), .channels_p(1),
                           .min_delay_p(3), .max_delay_p(3)) dut_d (
    .clk_i(clk), .reset_i(rst), .v_i(d_v_i), .data_i(d_data_i), .ready_and_o(d_rdy_o),
    .v_o(d_v_o), .data_o(d_data_o), .chan_o(d_chan_o), .ready_and_i(d_rdy_i),
    .count_o(d_count_o), .overflow_o(d_ovf_o)
  );

  // Output monitors: a transfer is committed at the next posedge.
  always @(negedge clk) begin
    if (a_v_o && a_rdy_i) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected: got 0x%0h, expected no transfer", a_data_o);
      end else check("a_data", a_data_o, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_v_o && b_rdy_i) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected: got 0x%0h, expected no transfer", b_data_o);
      end else begin
        bexp_t e;
        e = qb.pop_front();
        check("b_data", b_data_o, e.d);
        check("b_chan", b_chan_o, e.ch);
      end
    end
  end

  always @(negedge clk) begin
    if (d_v_o && d_rdy_i) begin
      d_cyc.push_back(cyc);
      if (qd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL d_unexpected: got 0x%0h, expected no transfer", d_data_o);
      end else check("d_data", d_data_o, qd.pop_front());
    end
  end

  int   c_last [2] = '{-1, -1};
  logic c_starved [2] = '{1'b0, 1'b0};
  logic c_contested [2] = '{1'b0, 1'b0};
  logic c_saw_lo = 1'b0, c_saw_hi = 1'b0;
  int   c_ch, c_gap;

  always @(negedge clk) begin
    // Entries pushed this cycle are not yet inside the DUT.
    for (int c = 0; c < 2; c++) begin
      if (qc[c].size() - int'(c_pend[c]) <= 0) c_starved[c] = 1'b1;
    end
    if (c_v_o && c_rdy_i) begin
      c_ch = int'(c_chan_o);
      if (qc[c_ch].size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL c_unexpected: got 0x%0h on ch %0d, expected no transfer", c_data_o, c_ch);
      end else begin
        check("c_data", c_data_o, qc[c_ch].pop_front());
        if (c_last[c_ch] >= 0) begin
          c_gap = cyc - c_last[c_ch];
          check_range("c_gap", c_gap, 3,
                      c_starved[c_ch] ? 32'h3fff_ffff : 6 + int'(c_contested[c_ch]));
          if (c_gap == 3) c_saw_lo = 1'b1;
          if (!c_starved[c_ch] && c_gap >= 6) c_saw_hi = 1'b1;
        end
        c_last[c_ch]        = cyc;
        c_starved[c_ch]     = 1'b0;
        c_contested[c_ch]   = 1'b0;
        c_contested[1-c_ch] = 1'b1;
      end
    end
  end

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        exp_v;
    logic [31:0] exp_d;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t tbl [5];
  int   pushes;

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b0, 32'h0,  5'd0};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 32'h11, 5'd1};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 32'h22, 5'd1};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 32'h33, 5'd1};
    tbl[4] = '{1'b0, 32'h0,  1'b0, 32'h0,  5'd0};

    rst = 1'b1;
    a_v_i = 0; a_data_i = 0; a_rdy_i = 0;
    b_v_i = 0; b_data_i = 0; b_rdy_i = 0;
    c_v_i = 0; c_data_i = 0; c_rdy_i = 1; c_pend = 0;
    d_v_i = 0; d_data_i = 0; d_rdy_i = 0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_v", a_v_o, 0);
    check("rst_a_count", a_count_o, 0);
    check("rst_a_ovf", a_ovf_o, 0);
    check("rst_a_ready", a_rdy_o, 1);
    check("rst_b_ready", b_rdy_o, 3'b111);
    check("rst_b_count", b_count_o, 0);
    check("rst_c_v", c_v_o, 0);

    // Single-channel pass-through latency
    a_rdy_i = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_v_i    = tbl[i].v;
      a_data_i = tbl[i].d;
      if (tbl[i].v) qa.push_back(tbl[i].d);
      @(negedge clk);
      check("tbl_v", a_v_o, tbl[i].exp_v);
      check("tbl_count", a_count_o, tbl[i].exp_cnt);
      if (tbl[i].exp_v) begin
        check("tbl_data", a_data_o, tbl[i].exp_d);
        check("tbl_chan", a_chan_o, 0);
      end
    end

    // Fill to full and push once more
    tick();
    a_rdy_i = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      a_v_i    = 1;
      a_data_i = 32'h100 + i;
      if (i < 16) qa.push_back(32'h100 + i);
      @(negedge clk);
      check("fill_ready", a_rdy_o, (i < 16) ? 1 : 0);
      check("fill_count", a_count_o, i);
      check("fill_ovf", a_ovf_o, 0);
    end
    tick();
    a_v_i = 0;
    @(negedge clk);
    check("full_ovf", a_ovf_o, 1);
    check("full_count", a_count_o, 16);
    check("full_ready", a_rdy_o, 0);
    tick();
    a_rdy_i = 1;
    for (int k = 0; k < 40 && qa.size() != 0; k++) @(negedge clk);
    check("a_drained", qa.size(), 0);
    tick();
    @(negedge clk);
    check("drain_count", a_count_o, 0);
    check("drain_ovf_sticky", a_ovf_o, 1);
    check("drain_v", a_v_o, 0);

    // Reset with 5 entries buffered
    a_rdy_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_v_i = 1;
      a_data_i = 32'h500 + i;
    end
    tick();
    a_v_i = 0;
    @(negedge clk);
    check("pre_rst_count", a_count_o, 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", a_count_o, 0);
    check("mid_rst_v", a_v_o, 0);
    check("mid_rst_ovf", a_ovf_o, 0);
    check("mid_rst_ready", a_rdy_o, 1);
    tick();
    a_rdy_i = 1;
    a_v_i = 1;
    a_data_i = 32'hABCD;
    qa.push_back(32'hABCD);
    tick();
    a_v_i = 0;
    for (int k = 0; k < 5 && qa.size() != 0; k++) @(negedge clk);
    check("post_rst_drained", qa.size(), 0);

    // Round-robin over three preloaded channels
    for (int k = 0; k < 4; k++) begin
      tick();
      b_v_i    = 3'b111;
      b_data_i = {32'(512 + k), 32'(256 + k), 32'(k)};
      for (int c = 0; c < 3; c++) qb.push_back('{32'(c * 256 + k), 2'(c)});
    end
    tick();
    b_v_i   = 0;
    b_rdy_i = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("b_busy", b_v_o, 1);
    end
    @(negedge clk);
    check("b_idle", b_v_o, 0);
    check("b_drained", qb.size(), 0);

    // Fixed delay of 3 between dequeues
    for (int i = 0; i < 2; i++) begin
      tick();
      d_v_i    = 1;
      d_data_i = 32'hD0 + i;
      qd.push_back(32'hD0 + i);
    end
    tick();
    d_v_i = 0;
    repeat (2) tick();
    d_rdy_i = 1;
    for (int k = 0; k < 20 && qd.size() != 0; k++) @(negedge clk);
    check("d_drained", qd.size(), 0);
    check("d_xfers", d_cyc.size(), 2);
    if (d_cyc.size() == 2) check("d_gap", d_cyc[1] - d_cyc[0], 4);

    // Random pushes under random dequeue delay
    pushes = 0;
    for (int g = 0; g < 10000 && pushes < 1000; g++) begin
      tick();
      for (int c = 0; c < 2; c++) begin
        c_v_i[c] = 0;
        if (c_rdy_o[c] && $urandom_range(0, 3) != 0 && pushes < 1000) begin
          c_v_i[c] = 1;
          c_data_i[c*32 +: 32] = {c[0], 31'(pushes)};
          qc[c].push_back({c[0], 31'(pushes)});
          pushes++;
        end
      end
      c_pend = c_v_i;
    end
    check("c_pushes", pushes, 1000);
    tick();
    c_v_i  = 0;
    c_pend = 0;
    for (int k = 0; k < 600 && (qc[0].size() + qc[1].size()) != 0; k++) @(negedge clk);
    check("c_drained", qc[0].size() + qc[1].size(), 0);
    check("c_saw_min_gap", c_saw_lo, 1);
    check("c_saw_max_gap", c_saw_hi, 1);
    check("c_no_ovf", c_ovf_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
